// File: rtl/interrupt_controller_if.sv
// Request/response bundle between the interrupt controller, its request sources and the
// multi-cycle core's control unit.
interface interrupt_controller_if;
    logic        mi_req;
    logic        mi_enable;
    logic        nmi_req;
    logic [3:0]  cu_state;
    logic [31:0] executed_instr;
    logic [1:0]  int_state;
    logic        int_respond;
    logic [31:0] int_vector;
    logic        int_is_nmi;
    logic        mi_ack;
    logic        nmi_ack;

    modport master (
        output mi_req, mi_enable, nmi_req, cu_state, executed_instr,
        input  int_state, int_respond, int_vector, int_is_nmi, mi_ack, nmi_ack
    );

    modport slave (
        input  mi_req, mi_enable, nmi_req, cu_state, executed_instr,
        output int_state, int_respond, int_vector, int_is_nmi, mi_ack, nmi_ack
    );
endinterface

// File: rtl/interrupt_controller.sv
// MI/NMI arbiter for the multi-cycle MIPS core: enters handlers at an instruction boundary
// and watches the executed instruction stream for the handler return word.
module interrupt_controller #(
    parameter logic [31:0] MI_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] NMI_VECTOR = 32'h0000_0200,
    parameter logic [31:0] MI_RET     = 32'd0,
    parameter logic [31:0] NMI_RET    = 32'd100
) (
    input logic                   clk,
    input logic                   rst_n,
    interrupt_controller_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StService = 2'd2
    } state_e;

    localparam logic [3:0] CuFetch  = 4'd0;
    localparam logic [3:0] CuDecode = 4'd1;

    state_e      state_q, state_d;
    logic        nmi_prev_q;
    logic        nmi_pend_q, nmi_pend_d;
    logic        respond_q, respond_d;
    logic [31:0] vector_q, vector_d;
    logic        is_nmi_q, is_nmi_d;
    logic        mi_ack_q, mi_ack_d;
    logic        nmi_ack_q, nmi_ack_d;

    logic        nmi_edge;
    logic        nmi_any;
    logic        mi_pend;
    logic        req_any;
    logic [31:0] ret_word;

    // An edge arriving this cycle counts as pending so it is never lost or delayed.
    assign nmi_edge = bus.nmi_req & ~nmi_prev_q;
    assign nmi_any  = nmi_pend_q | nmi_edge;
    assign mi_pend  = bus.mi_req & bus.mi_enable;
    assign req_any  = nmi_any | mi_pend;
    assign ret_word = is_nmi_q ? NMI_RET : MI_RET;

    always_comb begin
        state_d    = state_q;
        nmi_pend_d = nmi_pend_q | nmi_edge;
        respond_d  = respond_q;
        vector_d   = vector_q;
        is_nmi_d   = is_nmi_q;
        mi_ack_d   = 1'b0;
        nmi_ack_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (!req_any) begin
                    state_d = StIdle;
                end else if (bus.cu_state == CuDecode) begin
                    state_d  = StService;
                    is_nmi_d = nmi_any;
                    vector_d = nmi_any ? NMI_VECTOR : MI_VECTOR;
                    if (nmi_any) begin
                        nmi_pend_d = 1'b0;
                    end
                end
            end
            StService: begin
                if (bus.cu_state == CuFetch) begin
                    if (!respond_q) begin
                        respond_d = 1'b1;
                        mi_ack_d  = ~is_nmi_q;
                        nmi_ack_d = is_nmi_q;
                    end else if (bus.executed_instr == ret_word) begin
                        respond_d = 1'b0;
                        state_d   = req_any ? StPending : StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            respond_q  <= 1'b0;
            vector_q   <= 32'd0;
            is_nmi_q   <= 1'b0;
            mi_ack_q   <= 1'b0;
            nmi_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nmi_prev_q <= bus.nmi_req;
            nmi_pend_q <= nmi_pend_d;
            respond_q  <= respond_d;
            vector_q   <= vector_d;
            is_nmi_q   <= is_nmi_d;
            mi_ack_q   <= mi_ack_d;
            nmi_ack_q  <= nmi_ack_d;
        end
    end

    assign bus.int_state   = state_q;
    assign bus.int_respond = respond_q;
    assign bus.int_vector  = vector_q;
    assign bus.int_is_nmi  = is_nmi_q;
    assign bus.mi_ack      = mi_ack_q;
    assign bus.nmi_ack     = nmi_ack_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plus randomized bench for interrupt_controller, checked against a cycle-level
// reference model of the arbitration rules.
module tb_interrupt_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    interrupt_controller_if bus ();

    interrupt_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: phase 0 idle, 1 waiting for decode, 2 in handler.
    int          m_phase;
    bit          m_respond;
    bit          m_nmi;
    bit [31:0]   m_vec;
    bit          m_miack;
    bit          m_nmiack;
    bit          m_nmi_latched;
    bit          m_nmi_last;

    task automatic model_reset();
        m_phase = 0; m_respond = 0; m_nmi = 0; m_vec = 0;
        m_miack = 0; m_nmiack = 0; m_nmi_latched = 0; m_nmi_last = 0;
    endtask

    task automatic model_edge();
        bit mi_p;
        bit edge_now;
        bit nmi_waiting;
        mi_p        = bus.mi_req && bus.mi_enable;
        edge_now    = bus.nmi_req && !m_nmi_last;
        nmi_waiting = m_nmi_latched || edge_now;
        m_nmi_last  = bus.nmi_req;
        m_miack     = 0;
        m_nmiack    = 0;
        if (edge_now) m_nmi_latched = 1;
        if (m_phase == 0) begin
            if (nmi_waiting || mi_p) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!(nmi_waiting || mi_p)) begin
                m_phase = 0;
            end else if (bus.cu_state == 1) begin
                m_phase = 2;
                m_nmi   = nmi_waiting;
                m_vec   = nmi_waiting ? 32'h200 : 32'h100;
                if (nmi_waiting) m_nmi_latched = 0;
            end
        end else if (bus.cu_state == 0) begin
            if (!m_respond) begin
                m_respond = 1;
                if (m_nmi) m_nmiack = 1;
                else       m_miack  = 1;
            end else if (bus.executed_instr == (m_nmi ? 32'd100 : 32'd0)) begin
                m_respond = 0;
                m_phase   = (nmi_waiting || mi_p) ? 1 : 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},   32'(bus.int_state),   32'(m_phase));
        check({tag, ".respond"}, 32'(bus.int_respond), 32'(m_respond));
        check({tag, ".vector"},  bus.int_vector,       m_vec);
        check({tag, ".is_nmi"},  32'(bus.int_is_nmi),  32'(m_nmi));
        check({tag, ".mi_ack"},  32'(bus.mi_ack),      32'(m_miack));
        check({tag, ".nmi_ack"}, 32'(bus.nmi_ack),     32'(m_nmiack));
    endtask

    // One clock edge with the given control-unit inputs; outputs sampled 1 after the edge.
    task automatic cyc(input logic [3:0] cu, input logic [31:0] ei, input string tag);
        bus.cu_state       = cu;
        bus.executed_instr = ei;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n              = 1'b0;
        bus.mi_req         = 1'b0;
        bus.mi_enable      = 1'b0;
        bus.nmi_req        = 1'b0;
        bus.cu_state       = 4'd0;
        bus.executed_instr = 32'd55;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        check("reset.state_c", 32'(bus.int_state), 32'd0);
        #3 rst_n = 1'b1;

        // MI entry and return
        bus.mi_enable = 1'b1;
        bus.mi_req    = 1'b1;
        cyc(4'd0, 32'd55, "mi.pend");
        check("mi.pend_c", 32'(bus.int_state), 32'd1);
        cyc(4'd1, 32'd55, "mi.commit");
        check("mi.vec_c", bus.int_vector, 32'h100);
        cyc(4'd6, 32'd55, "mi.s6");
        cyc(4'd7, 32'd55, "mi.s7");
        cyc(4'd0, 32'd55, "mi.ack");
        check("mi.ack_c", 32'(bus.mi_ack), 32'd1);
        cyc(4'd1, 32'd55, "mi.ack_drop");
        bus.mi_req = 1'b0;
        cyc(4'd0, 32'd0, "mi.ret");
        check("mi.ret_c", 32'(bus.int_state), 32'd0);

        // NMI priority over simultaneous MI
        bus.mi_req  = 1'b1;
        bus.nmi_req = 1'b1;
        cyc(4'd0, 32'd55, "pri.pend");
        cyc(4'd1, 32'd55, "pri.commit");
        check("pri.vec_c", bus.int_vector, 32'h200);
        check("pri.nmi_c", 32'(bus.int_is_nmi), 32'd1);
        cyc(4'd0, 32'd55, "pri.ack");
        check("pri.ack_c", 32'(bus.nmi_ack), 32'd1);
        cyc(4'd2, 32'd55, "pri.run");
        cyc(4'd0, 32'd100, "pri.ret");
        check("pri.ret_c", 32'(bus.int_state), 32'd1);
        cyc(4'd1, 32'd55, "pri.mi_commit");
        cyc(4'd0, 32'd55, "pri.mi_ack");
        check("pri.mi_ack_c", 32'(bus.mi_ack), 32'd1);
        bus.mi_req  = 1'b0;
        bus.nmi_req = 1'b0;
        cyc(4'd0, 32'd0, "pri.mi_ret");

        // Masking
        bus.mi_req    = 1'b1;
        bus.mi_enable = 1'b0;
        cyc(4'd1, 32'd55, "mask.a");
        cyc(4'd1, 32'd55, "mask.b");
        check("mask.idle_c", 32'(bus.int_state), 32'd0);
        bus.mi_enable = 1'b1;
        cyc(4'd0, 32'd55, "mask.pend");
        bus.mi_req = 1'b0;
        cyc(4'd1, 32'd55, "mask.withdraw");
        check("mask.withdraw_c", 32'(bus.int_state), 32'd0);
        cyc(4'd0, 32'd55, "mask.noack");

        // NMI during MI handler, then NMI level held high
        bus.mi_req = 1'b1;
        cyc(4'd0, 32'd55, "nest.pend");
        cyc(4'd1, 32'd55, "nest.commit");
        cyc(4'd0, 32'd55, "nest.ack");
        bus.nmi_req = 1'b1;
        cyc(4'd2, 32'd55, "nest.nmi_edge");
        cyc(4'd0, 32'd100, "nest.wrong_ret");
        check("nest.wrong_ret_c", 32'(bus.int_state), 32'd2);
        bus.mi_req = 1'b0;
        cyc(4'd0, 32'd0, "nest.mi_ret");
        check("nest.mi_ret_c", 32'(bus.int_state), 32'd1);
        cyc(4'd1, 32'd55, "nest.nmi_commit");
        cyc(4'd0, 32'd55, "nest.nmi_ack");
        check("nest.nmi_ack_c", 32'(bus.nmi_ack), 32'd1);
        cyc(4'd0, 32'd100, "nest.nmi_ret");
        for (int i = 0; i < 4; i++) cyc(4'(i), 32'd55, "level.hold");
        check("level.once_c", 32'(bus.int_state), 32'd0);
        bus.nmi_req = 1'b0;
        cyc(4'd0, 32'd55, "level.low");
        bus.nmi_req = 1'b1;
        cyc(4'd0, 32'd55, "level.reedge");
        check("level.reedge_c", 32'(bus.int_state), 32'd1);

        // Asynchronous reset in the middle of a handler
        cyc(4'd1, 32'd55, "rst.commit");
        cyc(4'd0, 32'd55, "rst.ack");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_model("rst.async");
        bus.mi_req  = 1'b0;
        bus.nmi_req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(4'd1, 32'd55, "rst.after");
        check("rst.after_c", 32'(bus.int_state), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [3:0]  cu;
            logic [31:0] ei;
            r  = $urandom_range(0, 9);
            cu = (r < 4) ? 4'd0 : (r < 8) ? 4'd1 : 4'($urandom_range(2, 15));
            r  = $urandom_range(0, 3);
            ei = (r == 0) ? 32'd0 : (r == 1) ? 32'd100 : $urandom;
            if ($urandom_range(0, 5) == 0) bus.mi_req = ~bus.mi_req;
            if ($urandom_range(0, 15) == 0) bus.mi_enable = ~bus.mi_enable;
            if ($urandom_range(0, 7) == 0) bus.nmi_req = ~bus.nmi_req;
            cyc(cu, ei, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Arbitrates the maskable (MI) and non-maskable (NMI) interrupt requests of the multi-cycle MIPS core. It drives the control unit's `int_state` / `int_respond` inputs and the handler address selected when the control unit takes `PCSrc=3`. It tracks the control unit's `current_state` and `executedInstr` to place entry at an instruction boundary and to detect handler return.

## Interface
Parameters:
- `MI_VECTOR`, default 32'h0000_0100: MI handler address.
- `NMI_VECTOR`, default 32'h0000_0200: NMI handler address.
- `MI_RET`, default 32'd0: instruction word that ends an MI handler.
- `NMI_RET`, default 32'd100: instruction word that ends an NMI handler.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mi_req` in 1: maskable request, level-sensitive.
- `mi_enable` in 1: MI mask; 0 blocks MI.
- `nmi_req` in 1: non-maskable request, rising-edge-sensitive.
- `cu_state` in 4: control unit `current_state` (0 = fetch, 1 = decode).
- `executed_instr` in 32: control unit `executedInstr`.
- `int_state` out 2: 0 = IDLE, 1 = PENDING, 2 = SERVICE, 3 unused.
- `int_respond` out 1: 0 = not yet vectored, 1 = handler running.
- `int_vector` out 32: handler address for PCSrc=3.
- `int_is_nmi` out 1: cause latched at commit (1 = NMI).
- `mi_ack` out 1: one-cycle pulse when the MI is vectored.
- `nmi_ack` out 1: one-cycle pulse when the NMI is vectored.

## Operation
- Reset values: `int_state`=0, `int_respond`=0, `int_vector`=0, `int_is_nmi`=0, `mi_ack`=0, `nmi_ack`=0. The NMI edge register and `nmi_pend` also clear. Reset mid-service drops all pending and in-service interrupts.
- NMI latch:
  - `nmi_pend` sets on any edge where `nmi_req`=1 and the registered previous value is 0.
  - `nmi_pend` clears only when the NMI is committed.
  - An NMI edge during SERVICE stays latched.
- MI pending is combinational: `mi_pend = mi_req & mi_enable`. It is not latched.
- IDLE → PENDING on the edge where `nmi_pend` (or the edge being latched) or `mi_pend` is true.
- PENDING:
  - If neither request is pending, return to IDLE (MI withdrawn or masked).
  - Otherwise commit to SERVICE on the first edge with `cu_state`==1. This guarantees the control unit sees SERVICE at its next fetch edge.
  - Commit priority is NMI over MI.
  - At commit: load `int_is_nmi`, load `int_vector` with `NMI_VECTOR` or `MI_VECTOR`, and clear `nmi_pend` if the NMI was taken.
- SERVICE with `int_respond`=0: on the edge with `cu_state`==0 (the same edge on which the control unit vectors and stores PC), set `int_respond`=1 and pulse `mi_ack` or `nmi_ack` per `int_is_nmi`.
- SERVICE with `int_respond`=1: on an edge with `cu_state`==0 and `executed_instr` equal to the return word for the cause (`MI_RET` when `int_is_nmi`=0, otherwise `NMI_RET`):
  - Clear `int_respond`.
  - Go to PENDING if `nmi_pend` or `mi_pend` is set, else IDLE.
  - A matching word of the other cause is ignored.
- No nesting: an NMI does not preempt an MI handler. It is serviced after the MI returns.
- `int_vector` and `int_is_nmi` hold their values from commit until the next commit.

## Timing
- NMI edge → PENDING: 1 cycle (registered).
- PENDING → SERVICE: waits for the first `cu_state`==1 edge after PENDING is reached. Minimum 1 cycle.
- SERVICE entry → ack: the next `cu_state`==0 edge. The ack is high for exactly 1 cycle.
- Return → next entry: a back-to-back pending request goes to PENDING on the return edge. It commits at the following decode.
- Simultaneous NMI edge and return edge: NMI is latched and the next state is PENDING.
- Simultaneous MI withdrawal and decode edge in PENDING: with no NMI pending, go to IDLE. No commit.

## Test plan
- Reset mid-SERVICE: assert `rst_n`=0 asynchronously between edges → all outputs 0 immediately. After release, `int_state`=0 even with `mi_req` held 0.
- MI entry/return:
  - Stimulus: `mi_enable`=1, `mi_req`=1, then `cu_state` sequence 0,1,6,7,0.
  - Response: PENDING, then SERVICE at the decode edge, `int_vector`=32'h100.
  - At the next fetch edge: `int_respond`=1 and a 1-cycle `mi_ack`.
  - Drop `mi_req`, then `executed_instr`=0 at `cu_state`=0 → IDLE.
- NMI priority: MI and NMI pending together → commit with `int_is_nmi`=1, `int_vector`=32'h200, `nmi_ack` pulse. Return with `executed_instr`=100 → PENDING, then MI serviced.
- Masking: `mi_req`=1, `mi_enable`=0 → `int_state` stays 0. Set `mi_enable`=1 → PENDING. Drop `mi_req` before decode → IDLE, no ack.
- NMI during MI service: NMI rising edge with `int_respond`=1 and MI cause → no change. `executed_instr`=100 is ignored. `executed_instr`=0 at fetch → PENDING, then NMI vectored.
- NMI level held high: exactly one service; a second NMI requires a new 0→1 edge.
